// File: rtl/median_win_ctrl.sv
// Frame sequencer for the 3x3 median window: two line buffers, border rows, drain tail and output tagging.
// Define ZERO_PAD_EN to substitute zero border rows instead of replicating the edge lines.
module median_win_ctrl #(
   parameter int PIC_WIDTH  = 250,
   parameter int PIC_HEIGHT = 250,
   parameter int WIDTH      = 24,
   parameter int LAT        = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   input  logic             s_sof,
   input  logic [WIDTH-1:0] s_data,
   output logic             s_ready,
   output logic             win_valid,
   output logic [WIDTH-1:0] row_top,
   output logic [WIDTH-1:0] row_mid,
   output logic [WIDTH-1:0] row_bot,
   output logic             pix_tag,
   output logic             frame_done,
   output logic             sof_err
);
   localparam int          AW      = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
   localparam logic [10:0] COL_MAX = 11'(PIC_WIDTH - 1);
   localparam logic [10:0] ROW_MAX = 11'(PIC_HEIGHT - 1);
   localparam logic [10:0] DRN_MAX = 11'(LAT - 1);

   typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DRAIN} state_t;
   typedef struct packed {
      logic [WIDTH-1:0] top;
      logic [WIDTH-1:0] mid;
      logic [WIDTH-1:0] bot;
   } taps_t;

   state_t           state, state_nx;
   logic [10:0]      col, row, col_nx, row_nx;
   logic [LAT-1:0]   tag_pipe, tag_nx;
   logic [WIDTH-1:0] lb1 [PIC_WIDTH];
   logic [WIDTH-1:0] lb2 [PIC_WIDTH];
   logic [AW-1:0]    ci, wr_idx;
   logic [WIDTH-1:0] lb1_rd, lb2_rd, top_border, bot_border;
   logic             acc, restart, wr;
   logic             vld_nx, shift_in, tag_clr, sof_err_nx, done_nx, ready_nx, pix_tag_nx;
   taps_t            taps_q, taps_nx;

   assign acc     = s_valid & s_ready;
   assign restart = acc & s_sof;
   assign wr      = acc & (s_sof | (state != IDLE));
   assign ci      = col[AW-1:0];
   // a restart pixel always lands in column 0 regardless of where the aborted frame was
   assign wr_idx  = restart ? '0 : ci;
   assign lb1_rd  = lb1[ci];
   assign lb2_rd  = lb2[ci];

`ifdef ZERO_PAD_EN
   assign top_border = '0;
   assign bot_border = '0;
`else
   assign top_border = lb1_rd;
   assign bot_border = lb1_rd;
`endif

   always_ff @(posedge clk) begin
      if (wr) begin
         lb2[wr_idx] <= lb1[wr_idx];
         lb1[wr_idx] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         col   <= '0;
         row   <= '0;
      end else begin
         state <= state_nx;
         col   <= col_nx;
         row   <= row_nx;
      end
   end

   always_comb begin
      state_nx = state;
      col_nx   = col;
      row_nx   = row;
      if (restart) begin
         state_nx = FILL;
         col_nx   = 11'd1;
         row_nx   = '0;
      end else begin
         case (state)
            FILL: if (acc) begin
               if (col == COL_MAX) begin
                  state_nx = RUN;
                  col_nx   = '0;
                  row_nx   = 11'd1;
               end else col_nx = col + 11'd1;
            end
            RUN: if (acc) begin
               if (col == COL_MAX) begin
                  col_nx = '0;
                  if (row == ROW_MAX) state_nx = FLUSH;
                  else                row_nx   = row + 11'd1;
               end else col_nx = col + 11'd1;
            end
            FLUSH: begin
               if (col == COL_MAX) begin
                  state_nx = DRAIN;
                  col_nx   = '0;
               end else col_nx = col + 11'd1;
            end
            DRAIN: begin
               if (col == DRN_MAX) begin
                  state_nx = IDLE;
                  col_nx   = '0;
                  row_nx   = '0;
               end else col_nx = col + 11'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      vld_nx     = 1'b0;
      shift_in   = 1'b0;
      tag_clr    = 1'b0;
      sof_err_nx = 1'b0;
      done_nx    = 1'b0;
      taps_nx    = taps_q;
      if (restart) begin
         tag_clr    = 1'b1;
         sof_err_nx = (state != IDLE);
      end else begin
         case (state)
            RUN: if (acc) begin
               vld_nx      = 1'b1;
               shift_in    = 1'b1;
               taps_nx.top = (row == 11'd1) ? top_border : lb2_rd;
               taps_nx.mid = lb1_rd;
               taps_nx.bot = s_data;
            end
            FLUSH: begin
               vld_nx      = 1'b1;
               shift_in    = 1'b1;
               taps_nx.top = lb2_rd;
               taps_nx.mid = lb1_rd;
               taps_nx.bot = bot_border;
            end
            DRAIN: begin
               vld_nx  = 1'b1;
               taps_nx = '0;
               done_nx = (col == DRN_MAX);
            end
            default: ;
         endcase
      end
      ready_nx   = (state_nx != FLUSH) && (state_nx != DRAIN);
      pix_tag_nx = vld_nx & tag_pipe[LAT-1];
   end

   generate
      if (LAT == 1) begin : g_tag1
         assign tag_nx = shift_in;
      end else begin : g_tagn
         assign tag_nx = {tag_pipe[LAT-2:0], shift_in};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_pipe   <= '0;
         s_ready    <= 1'b1;
         win_valid  <= 1'b0;
         pix_tag    <= 1'b0;
         frame_done <= 1'b0;
         sof_err    <= 1'b0;
         taps_q     <= '0;
      end else begin
         if (tag_clr)     tag_pipe <= '0;
         else if (vld_nx) tag_pipe <= tag_nx;
         s_ready    <= ready_nx;
         win_valid  <= vld_nx;
         pix_tag    <= pix_tag_nx;
         frame_done <= done_nx;
         sof_err    <= sof_err_nx;
         taps_q     <= taps_nx;
      end
   end

   assign row_top = taps_q.top;
   assign row_mid = taps_q.mid;
   assign row_bot = taps_q.bot;
endmodule

// File: tb/tb_median_win_ctrl.sv
// Directed bench for median_win_ctrl on a 4x3 frame with LAT=3; expected beats come from a hand-written table.
module tb_median_win_ctrl;
   localparam int PW = 4, PH = 3, W = 8, LT = 3, NB = PW * PH + LT;
`ifdef ZERO_PAD_EN
   localparam bit ZP = 1'b1;
`else
   localparam bit ZP = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] top, mid, bot;
      logic         tag;
   } beat_t;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic         s_valid = 1'b0, s_sof = 1'b0;
   logic [W-1:0] s_data = '0;
   logic         s_ready, win_valid, pix_tag, frame_done, sof_err;
   logic [W-1:0] row_top, row_mid, row_bot;

   median_win_ctrl #(.PIC_WIDTH(PW), .PIC_HEIGHT(PH), .WIDTH(W), .LAT(LT)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_sof(s_sof), .s_data(s_data),
      .s_ready(s_ready), .win_valid(win_valid), .row_top(row_top), .row_mid(row_mid),
      .row_bot(row_bot), .pix_tag(pix_tag), .frame_done(frame_done), .sof_err(sof_err)
   );

   always #5 clk = ~clk;

   int    cyc = 0;
   int    n_chk = 0, n_pass = 0;
   beat_t beats[$];
   int    beat_cyc[$], acc_cyc[$], done_cyc[$];
   int    sof_err_cnt = 0;
   beat_t exp_tab[NB];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (win_valid) begin
         beats.push_back('{row_top, row_mid, row_bot, pix_tag});
         beat_cyc.push_back(cyc);
      end
      if (s_valid && s_ready) acc_cyc.push_back(cyc);
      if (frame_done) done_cyc.push_back(cyc);
      if (sof_err) sof_err_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   task automatic clear_mon();
      beats.delete(); beat_cyc.delete(); acc_cyc.delete(); done_cyc.delete();
      sof_err_cnt = 0;
   endtask

   task automatic send(input logic [W-1:0] d, input logic sof, input int gap);
      int t = 0;
      s_valid = 1'b1; s_data = d; s_sof = sof;
      while (!s_ready && t < 50) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      s_valid = 1'b0; s_sof = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic send_frame(input int gap);
      for (int p = 1; p <= PW * PH; p++) send(W'(p), p == 1, gap);
   endtask

   task automatic wait_done(input string name);
      int t = 0;
      while (done_cyc.size() == 0 && t < 200) begin @(posedge clk); #1; t++; end
      repeat (4) begin @(posedge clk); #1; end
      chk({name, "_done_seen"}, 32'(done_cyc.size() > 0), 32'd1);
   endtask

   task automatic cmp_frame(input string name, input int base);
      int tags = 0;
      if (beats.size() < base + NB) begin
         chk({name, "_beat_count"}, 32'(beats.size()), 32'(base + NB));
         return;
      end
      for (int i = 0; i < NB; i++) begin
         chk($sformatf("%s_beat%0d", name, i),
             {7'd0, beats[base+i].top, beats[base+i].mid, beats[base+i].bot, beats[base+i].tag},
             {7'd0, exp_tab[i].top, exp_tab[i].mid, exp_tab[i].bot, exp_tab[i].tag});
      end
      foreach (beats[i]) tags += int'(beats[i].tag);
      chk({name, "_tags"}, 32'(tags), 32'(PW * PH));
      chk({name, "_done_cnt"}, 32'(done_cyc.size()), 32'd1);
      if (done_cyc.size() > 0) begin
         chk({name, "_done_lat"}, 32'(done_cyc[0]), 32'(beat_cyc[base+PW*PH-1] + LT));
         chk({name, "_tail_contig"}, 32'(beat_cyc[base+NB-1] - beat_cyc[base+2*PW]), 32'(PW + LT - 1));
      end
   endtask

   initial begin
      // line 1: top border, line 2: full window, flush: bottom border, drain: zeros
      exp_tab[0]  = '{ZP ? 8'd0 : 8'd1, 8'd1, 8'd5, 1'b0};
      exp_tab[1]  = '{ZP ? 8'd0 : 8'd2, 8'd2, 8'd6, 1'b0};
      exp_tab[2]  = '{ZP ? 8'd0 : 8'd3, 8'd3, 8'd7, 1'b0};
      exp_tab[3]  = '{ZP ? 8'd0 : 8'd4, 8'd4, 8'd8, 1'b1};
      exp_tab[4]  = '{8'd1, 8'd5, 8'd9,  1'b1};
      exp_tab[5]  = '{8'd2, 8'd6, 8'd10, 1'b1};
      exp_tab[6]  = '{8'd3, 8'd7, 8'd11, 1'b1};
      exp_tab[7]  = '{8'd4, 8'd8, 8'd12, 1'b1};
      exp_tab[8]  = '{8'd5, 8'd9,  ZP ? 8'd0 : 8'd9,  1'b1};
      exp_tab[9]  = '{8'd6, 8'd10, ZP ? 8'd0 : 8'd10, 1'b1};
      exp_tab[10] = '{8'd7, 8'd11, ZP ? 8'd0 : 8'd11, 1'b1};
      exp_tab[11] = '{8'd8, 8'd12, ZP ? 8'd0 : 8'd12, 1'b1};
      exp_tab[12] = '{8'd0, 8'd0, 8'd0, 1'b1};
      exp_tab[13] = '{8'd0, 8'd0, 8'd0, 1'b1};
      exp_tab[14] = '{8'd0, 8'd0, 8'd0, 1'b1};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", 32'(s_ready), 32'd1);
      chk("rst_outs", {27'd0, win_valid, pix_tag, frame_done, sof_err, 1'b0}, 32'd0);
      chk("rst_taps", {8'd0, row_top, row_mid, row_bot}, 32'd0);

      // continuous frame
      clear_mon();
      send_frame(0);
      wait_done("t1");
      cmp_frame("t1", 0);
      if (acc_cyc.size() >= 5 && beat_cyc.size() > 0)
         chk("t1_first_lat", 32'(beat_cyc[0]), 32'(acc_cyc[4] + 1));
      chk("t1_sof_err", 32'(sof_err_cnt), 32'd0);
      chk("t1_ready_after", 32'(s_ready), 32'd1);

      // gapped input: beats only follow accepted pixels
      clear_mon();
      send_frame(1);
      wait_done("t2");
      cmp_frame("t2", 0);
      if (acc_cyc.size() >= PW * PH && beat_cyc.size() >= 2 * PW) begin
         int bad = 0;
         for (int i = 0; i < 2 * PW; i++) if (beat_cyc[i] != acc_cyc[i+PW] + 1) bad++;
         chk("t2_beat_align", 32'(bad), 32'd0);
      end

      // junk before start of frame is dropped
      clear_mon();
      for (int i = 0; i < 3; i++) send(8'hAA, 1'b0, 0);
      repeat (3) begin @(posedge clk); #1; end
      chk("t3_no_beats", 32'(beats.size()), 32'd0);
      send_frame(0);
      wait_done("t3");
      cmp_frame("t3", 0);

      // restart at line 1 column 2
      clear_mon();
      for (int p = 1; p <= 6; p++) send(W'(p), p == 1, 0);
      send_frame(0);
      wait_done("t4");
      chk("t4_sof_err", 32'(sof_err_cnt), 32'd1);
      chk("t4_aborted_beats", {8'd0, beats[0].top, beats[0].mid, beats[0].bot},
          {8'd0, ZP ? 8'd0 : 8'd1, 8'd1, 8'd5});
      cmp_frame("t4", 2);

      // async reset during FLUSH
      clear_mon();
      send_frame(0);
      @(posedge clk); #3;
      chk("t5_in_flush", 32'(s_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_ready", 32'(s_ready), 32'd1);
      chk("t5_rst_outs", {28'd0, win_valid, pix_tag, frame_done, sof_err}, 32'd0);
      chk("t5_rst_taps", {8'd0, row_top, row_mid, row_bot}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      clear_mon();
      send_frame(0);
      wait_done("t5");
      cmp_frame("t5", 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
